// File: rtl/alu_cmd_sequencer.sv
// Command-side controller for the 32-bit combinational ALU: operand register file,
// one ALU operation per command, result/flags/tag returned over a valid/ready response.
// Optional: define ALU_OVF_COUNT_EN to build the 8-bit saturating overflow counter.
module alu_cmd_sequencer #(
    parameter int unsigned NREGS = 8,
    parameter int unsigned TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [4:0]               cmd_op,
    input  logic [$clog2(NREGS)-1:0] cmd_rd,
    input  logic [$clog2(NREGS)-1:0] cmd_rs1,
    input  logic [$clog2(NREGS)-1:0] cmd_rs2,
    input  logic [4:0]               cmd_shamt,
    input  logic                     cmd_cin,
    input  logic [TAG_W-1:0]         cmd_tag,

    input  logic                     load_en,
    input  logic [$clog2(NREGS)-1:0] load_addr,
    input  logic [31:0]              load_data,

    output logic [31:0]              alu_A,
    output logic [31:0]              alu_B,
    output logic                     alu_cin,
    output logic [4:0]               alu_shamt,
    output logic [4:0]               alu_opcode,
    input  logic [31:0]              alu_result,
    input  logic                     alu_carryout,
    input  logic                     alu_overflow,
    input  logic                     alu_zero,

    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_data,
    output logic [3:0]               rsp_flags,
    output logic [TAG_W-1:0]         rsp_tag,

    output logic [7:0]               ovf_count
);

    localparam int unsigned AW     = $clog2(NREGS);
    localparam logic [4:0]  OP_MAX = 5'd10;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic              accept;
    logic              capture;
    logic              op_valid;
    logic              wb_en;

    logic [31:0]       rf_q [NREGS];

    logic [AW-1:0]     rd_q;
    logic [TAG_W-1:0]  tag_q;
    logic [31:0]       alu_a_q;
    logic [31:0]       alu_b_q;
    logic              alu_cin_q;
    logic [4:0]        alu_shamt_q;
    logic [4:0]        alu_opcode_q;

    logic [31:0]       rsp_data_q;
    logic [3:0]        rsp_flags_q;
    logic [TAG_W-1:0]  rsp_tag_q;

    // ---------------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = StExec;
                end
            end
            StExec: begin
                capture = 1'b1;
                state_d = StResp;
            end
            StResp: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign op_valid = (alu_opcode_q <= OP_MAX);
    assign wb_en    = capture && op_valid && (rd_q != '0);

    // ---------------------------------------------------------------------
    // Command snapshot; also the ALU drive registers, which hold between commands
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q         <= '0;
            tag_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_cin_q    <= 1'b0;
            alu_shamt_q  <= '0;
            alu_opcode_q <= '0;
        end else if (accept) begin
            rd_q         <= cmd_rd;
            tag_q        <= cmd_tag;
            alu_a_q      <= rf_q[cmd_rs1];
            alu_b_q      <= rf_q[cmd_rs2];
            alu_cin_q    <= cmd_cin;
            alu_shamt_q  <= cmd_shamt;
            alu_opcode_q <= cmd_op;
        end
    end

    assign alu_A      = alu_a_q;
    assign alu_B      = alu_b_q;
    assign alu_cin    = alu_cin_q;
    assign alu_shamt  = alu_shamt_q;
    assign alu_opcode = alu_opcode_q;

    // ---------------------------------------------------------------------
    // Register file: host loads in any state; a same-cycle writeback to the
    // same address is ordered last so it wins. Entry 0 is never written.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            if (load_en && (load_addr != '0)) begin
                rf_q[load_addr] <= load_data;
            end
            if (wb_en) begin
                rf_q[rd_q] <= alu_result;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Response capture
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
            rsp_tag_q   <= '0;
        end else if (capture) begin
            rsp_tag_q <= tag_q;
            if (op_valid) begin
                rsp_data_q  <= alu_result;
                rsp_flags_q <= {1'b0, alu_zero, alu_overflow, alu_carryout};
            end else begin
                // Unknown opcode: ALU outputs are ignored, report err with a zero result
                rsp_data_q  <= '0;
                rsp_flags_q <= 4'b1100;
            end
        end
    end

    assign rsp_data  = rsp_data_q;
    assign rsp_flags = rsp_flags_q;
    assign rsp_tag   = rsp_tag_q;

    // ---------------------------------------------------------------------
    // Overflow counter
    // ---------------------------------------------------------------------
`ifdef ALU_OVF_COUNT_EN
    logic [7:0] ovf_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_count_q <= '0;
        end else if (capture && op_valid && alu_overflow && (ovf_count_q != 8'hFF)) begin
            ovf_count_q <= ovf_count_q + 8'd1;
        end
    end

    assign ovf_count = ovf_count_q;
`else
    assign ovf_count = 8'd0;
`endif

endmodule
